// File: rtl/tc_bias_pkg.sv
// Shared types and default widths for the bias scheduler.
package tc_bias_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 8;

  // Loader sequencing: wait for a request, stream reads, land the last word.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } load_state_e;

endpackage

// File: rtl/bias_scheduler_if.sv
// Configuration handshake and bias SRAM read port of the bias scheduler.
interface bias_scheduler_if
  import tc_bias_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROW_W  = 8
);
  logic              cfg_start;
  logic [ADDR_W-1:0] cfg_base_addr;
  logic [ROW_W-1:0]  cfg_rows;
  logic              cfg_ready;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;

  // Scheduler side: takes config requests, issues SRAM reads.
  modport slave (
    input  cfg_start, cfg_base_addr, cfg_rows, mem_rd_data,
    output cfg_ready, mem_rd_en, mem_rd_addr
  );

  // Controller / SRAM side.
  modport master (
    output cfg_start, cfg_base_addr, cfg_rows, mem_rd_data,
    input  cfg_ready, mem_rd_en, mem_rd_addr
  );
endinterface

// File: rtl/bias_col_tracker.sv
// Per-column row counter: follows the column's own systolic valid and
// flips that lane to the other bank right after the tile's last row.
module bias_col_tracker #(
  parameter int ROW_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [ROW_W-1:0] rows0_i,
  input  logic [ROW_W-1:0] rows1_i,
  input  logic [1:0]       bank_full_i,
  output logic             rd_ptr_o,
  output logic             wrap_o,
  output logic             underrun_o
);

  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
  logic [ROW_W-1:0] rows_sel;
  logic             rd_ptr_q, rd_ptr_d;
  logic             last_row;

  // Row count and bank pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_cnt_q <= '0;
      rd_ptr_q  <= 1'b0;
    end else begin
      row_cnt_q <= row_cnt_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Advance on valid; wrap and swap banks on the last row of the tile.
  always_comb begin
    rows_sel   = rd_ptr_q ? rows1_i : rows0_i;
    last_row   = (row_cnt_q == rows_sel - ROW_W'(1));
    row_cnt_d  = row_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wrap_o     = 1'b0;
    underrun_o = 1'b0;
    if (valid_i) begin
      // Counting continues on an empty bank; the flag only reports it.
      underrun_o = !bank_full_i[rd_ptr_q];
      if (last_row) begin
        row_cnt_d = '0;
        rd_ptr_d  = !rd_ptr_q;
        wrap_o    = 1'b1;
      end else begin
        row_cnt_d = row_cnt_q + ROW_W'(1);
      end
    end
  end

  assign rd_ptr_o = rd_ptr_q;

endmodule

// File: rtl/bias_scheduler.sv
// Double-buffered bias bank: loads per-column bias words from SRAM into the
// idle bank while the lanes consume the other, each lane switching on its own
// skewed row count.
module bias_scheduler
  import tc_bias_pkg::*;
#(
  parameter int COLS   = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int ROW_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  bias_scheduler_if.slave        bus,
  input  logic [COLS-1:0]        sys_valid_in,
  output logic [COLS*DATA_W-1:0] bias_scalar_out,
  output logic [1:0]             bank_full,
  output logic                   err_underrun
);

  localparam int IDX_W = (COLS > 1) ? $clog2(COLS) : 1;

  load_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              fill_ptr_q;
  logic [ROW_W-1:0]  rows_q [2];
  logic [1:0]        bank_full_q, bank_full_d;
  logic [DATA_W-1:0] bank_q [2][COLS];
  logic              wr_pend_q;
  logic [IDX_W-1:0]  wr_idx_q;
  logic              err_q;

  logic              rd_en, cfg_ready, load_accept, load_done;
  logic [ADDR_W-1:0] rd_addr;
  logic [COLS-1:0]   rd_ptr, col_wrap, col_underrun;

  // Loader state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
    end
  end

  // Loader next-state and read strobes.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    base_d      = base_q;
    rd_en       = 1'b0;
    rd_addr     = '0;
    cfg_ready   = 1'b0;
    load_accept = 1'b0;
    load_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cfg_ready = !bank_full_q[fill_ptr_q];
        if (bus.cfg_start && cfg_ready) begin
          base_d      = bus.cfg_base_addr;
          idx_d       = '0;
          load_accept = 1'b1;
          state_d     = ST_FETCH;
        end
      end
      ST_FETCH: begin
        rd_en   = 1'b1;
        rd_addr = base_q + ADDR_W'(idx_q);
        if (idx_q == IDX_W'(COLS - 1)) state_d = ST_DRAIN;
        else                           idx_d   = idx_q + IDX_W'(1);
      end
      ST_DRAIN: begin
        load_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Fill pointer, tile row counts, and write-back of returning SRAM data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_ptr_q <= 1'b0;
      rows_q[0]  <= ROW_W'(1);
      rows_q[1]  <= ROW_W'(1);
      wr_pend_q  <= 1'b0;
      wr_idx_q   <= '0;
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < COLS; c++)
          bank_q[b][c] <= '0;
    end else begin
      wr_pend_q <= rd_en;
      wr_idx_q  <= idx_q;
      if (load_accept)
        rows_q[fill_ptr_q] <= (bus.cfg_rows == '0) ? ROW_W'(1) : bus.cfg_rows;
      if (wr_pend_q)
        bank_q[fill_ptr_q][wr_idx_q] <= bus.mem_rd_data;
      if (load_done)
        fill_ptr_q <= !fill_ptr_q;
    end
  end

  // Last column finishing a bank frees it; a completed load marks its bank.
  always_comb begin
    bank_full_d = bank_full_q;
    if (col_wrap[COLS-1]) bank_full_d[rd_ptr[COLS-1]] = 1'b0;
    if (load_done)        bank_full_d[fill_ptr_q]     = 1'b1;
  end

  // Bank occupancy and sticky underrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_full_q <= '0;
      err_q       <= 1'b0;
    end else begin
      bank_full_q <= bank_full_d;
      err_q       <= err_q | (|col_underrun);
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    bias_col_tracker #(.ROW_W(ROW_W)) u_trk (
      .clk         (clk),
      .rst         (rst),
      .valid_i     (sys_valid_in[c]),
      .rows0_i     (rows_q[0]),
      .rows1_i     (rows_q[1]),
      .bank_full_i (bank_full_q),
      .rd_ptr_o    (rd_ptr[c]),
      .wrap_o      (col_wrap[c]),
      .underrun_o  (col_underrun[c])
    );
  end

  // Each lane reads its own bank straight from the registers.
  always_comb begin
    bias_scalar_out = '0;
    for (int c = 0; c < COLS; c++)
      bias_scalar_out[c*DATA_W +: DATA_W] = bank_q[rd_ptr[c]][c];
  end

  assign bus.cfg_ready   = cfg_ready;
  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_rd_addr = rd_addr;
  assign bank_full       = bank_full_q;
  assign err_underrun    = err_q;

endmodule

// File: tb/tb_bias_scheduler.sv
// Directed bench for bias_scheduler with a one-cycle-latency SRAM model.
module tb_bias_scheduler;

  localparam int COLS = 4;
  localparam int DW   = 32;
  localparam int AW   = 8;
  localparam int RW   = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [COLS-1:0] sys_valid_in = '0;
  logic [COLS*DW-1:0] bias_scalar_out;
  logic [1:0]      bank_full;
  logic            err_underrun;
  logic [DW-1:0]   mem [256];

  int n_assert = 0;
  int n_fail   = 0;

  bias_scheduler_if #(.ADDR_W(AW), .DATA_W(DW), .ROW_W(RW)) bus ();

  bias_scheduler #(.COLS(COLS), .DATA_W(DW), .ADDR_W(AW), .ROW_W(RW)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .sys_valid_in    (sys_valid_in),
    .bias_scalar_out (bias_scalar_out),
    .bank_full       (bank_full),
    .err_underrun    (err_underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input string tag, input logic [7:0] base, input logic [7:0] rows,
                         input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] a2, input logic [7:0] a3);
    logic [7:0] exp_addr [4];
    exp_addr[0] = a0; exp_addr[1] = a1; exp_addr[2] = a2; exp_addr[3] = a3;
    bus.cfg_start     = 1'b1;
    bus.cfg_base_addr = base;
    bus.cfg_rows      = rows;
    tick();
    bus.cfg_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_rd_en"}, 128'(bus.mem_rd_en), 128'(1));
      check({tag, "_rd_addr"}, 128'(bus.mem_rd_addr), 128'(exp_addr[i]));
      tick();
    end
    check({tag, "_drain_rd_en"}, 128'(bus.mem_rd_en), 128'(0));
    tick();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = '0;
    mem[8'h10] = 32'd10;  mem[8'h11] = 32'hFFFF_FFEC;
    mem[8'h12] = 32'd30;  mem[8'h13] = 32'hFFFF_FFD8;
    mem[8'h20] = 32'd1;   mem[8'h21] = 32'd2;
    mem[8'h22] = 32'd3;   mem[8'h23] = 32'd4;
    mem[8'hFE] = 32'd100; mem[8'hFF] = 32'd200;
    mem[8'h00] = 32'd300; mem[8'h01] = 32'd400;
    bus.cfg_start = 1'b0; bus.cfg_base_addr = '0; bus.cfg_rows = '0;
    bus.mem_rd_data = '0;

    // Reset and idle values
    tick(); tick();
    rst = 1'b1;
    check("rst_bank_full", 128'(bank_full), 128'(0));
    check("rst_err", 128'(err_underrun), 128'(0));
    check("rst_cfg_ready", 128'(bus.cfg_ready), 128'(1));
    check("rst_rd_en", 128'(bus.mem_rd_en), 128'(0));
    check("rst_rd_addr", 128'(bus.mem_rd_addr), 128'(0));
    check("rst_bias", bias_scalar_out, 128'(0));

    // Bank 0 load {10,-20,30,-40} at 0x10, rows=2
    do_load("ld0", 8'h10, 8'd2, 8'h10, 8'h11, 8'h12, 8'h13);
    check("ld0_full", 128'(bank_full), 128'(2'b01));
    check("ld0_ready", 128'(bus.cfg_ready), 128'(1));
    check("ld0_bias", bias_scalar_out, {32'hFFFF_FFD8, 32'd30, 32'hFFFF_FFEC, 32'd10});

    // Bank 1 load {1,2,3,4} at 0x20, rows=2
    do_load("ld1", 8'h20, 8'd2, 8'h20, 8'h21, 8'h22, 8'h23);
    check("ld1_full", 128'(bank_full), 128'(2'b11));
    check("ld1_ready", 128'(bus.cfg_ready), 128'(0));

    // Both banks full: request ignored
    bus.cfg_start = 1'b1; bus.cfg_base_addr = 8'h30; bus.cfg_rows = 8'd2;
    tick();
    bus.cfg_start = 1'b0;
    check("full_no_rd", 128'(bus.mem_rd_en), 128'(0));
    tick();
    check("full_no_rd2", 128'(bus.mem_rd_en), 128'(0));
    check("full_ready", 128'(bus.cfg_ready), 128'(0));

    // Skewed valids, two rows per column
    sys_valid_in = 4'b0001; tick();
    check("skew0_bias", bias_scalar_out, {32'hFFFF_FFD8, 32'd30, 32'hFFFF_FFEC, 32'd10});
    sys_valid_in = 4'b0011; tick();
    check("skew1_bias", bias_scalar_out, {32'hFFFF_FFD8, 32'd30, 32'hFFFF_FFEC, 32'd1});
    sys_valid_in = 4'b0110; tick();
    check("skew2_bias", bias_scalar_out, {32'hFFFF_FFD8, 32'd30, 32'd2, 32'd1});
    sys_valid_in = 4'b1100; tick();
    check("skew3_bias", bias_scalar_out, {32'hFFFF_FFD8, 32'd3, 32'd2, 32'd1});
    check("skew3_full", 128'(bank_full), 128'(2'b11));
    check("skew3_ready", 128'(bus.cfg_ready), 128'(0));
    sys_valid_in = 4'b1000; tick();
    sys_valid_in = 4'b0000;
    check("skew4_bias", bias_scalar_out, {32'd4, 32'd3, 32'd2, 32'd1});
    check("skew4_full", 128'(bank_full), 128'(2'b10));
    check("skew4_ready", 128'(bus.cfg_ready), 128'(1));
    check("skew4_err", 128'(err_underrun), 128'(0));

    // Wrapping address load with rows=0 into bank 0
    do_load("ldw", 8'hFE, 8'd0, 8'hFE, 8'hFF, 8'h00, 8'h01);
    check("ldw_full", 128'(bank_full), 128'(2'b11));
    sys_valid_in = 4'b1111; tick();
    check("all0_bias", bias_scalar_out, {32'd4, 32'd3, 32'd2, 32'd1});
    tick();
    check("all1_bias", bias_scalar_out, {32'd400, 32'd300, 32'd200, 32'd100});
    check("all1_full", 128'(bank_full), 128'(2'b01));
    tick();
    sys_valid_in = 4'b0000;
    check("row1_bias", bias_scalar_out, {32'd4, 32'd3, 32'd2, 32'd1});
    check("row1_full", 128'(bank_full), 128'(2'b00));
    check("row1_err", 128'(err_underrun), 128'(0));

    // Underrun on an empty bank, then a good load into bank 1
    sys_valid_in = 4'b0001; tick();
    sys_valid_in = 4'b0000;
    check("udr_err", 128'(err_underrun), 128'(1));
    do_load("ldu", 8'h10, 8'd2, 8'h10, 8'h11, 8'h12, 8'h13);
    check("ldu_full", 128'(bank_full), 128'(2'b10));
    check("ldu_err", 128'(err_underrun), 128'(1));
    check("ldu_bias", bias_scalar_out, {32'hFFFF_FFD8, 32'd30, 32'hFFFF_FFEC, 32'd10});

    // Reset in the middle of a fetch
    bus.cfg_start = 1'b1; bus.cfg_base_addr = 8'h20; bus.cfg_rows = 8'd2;
    tick();
    bus.cfg_start = 1'b0;
    check("abort_rd0", 128'(bus.mem_rd_addr), 128'(8'h20));
    tick();
    check("abort_rd1", 128'(bus.mem_rd_addr), 128'(8'h21));
    rst = 1'b0;
    #1;
    check("abort_rd_en", 128'(bus.mem_rd_en), 128'(0));
    check("abort_full", 128'(bank_full), 128'(0));
    check("abort_err", 128'(err_underrun), 128'(0));
    check("abort_bias", bias_scalar_out, 128'(0));
    tick(); tick();
    rst = 1'b1;
    check("post_ready", 128'(bus.cfg_ready), 128'(1));
    tick(); tick();
    check("post_full", 128'(bank_full), 128'(0));
    check("post_bias", bias_scalar_out, 128'(0));
    check("post_rd_en", 128'(bus.mem_rd_en), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
